// File: rtl/orbtrace_pkg.sv
// Shared types and widths for the trace frame path
// between the frame assembler and the SPI stage.
package orbtrace_pkg;

    localparam int FRAME_W = 128;
    localparam int LOST_W  = 16;
    localparam int TOTAL_W = 32;

    typedef enum logic [1:0] {
        HF_EMPTY,
        HF_FETCH,
        HF_VALID
    } hf_state_t;

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port frame store: one write port and one
// registered read port, inferable as block RAM.
module frame_ram
    import orbtrace_pkg::*;
#(
    parameter int AW = 9
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [FRAME_W-1:0] wdata,
    input  logic               re,
    input  logic [AW-1:0]      raddr,
    output logic [FRAME_W-1:0] rdata
);

    logic [FRAME_W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/frame_buffer.sv
// Trace frame FIFO with a prefetched head register,
// occupancy count and lost/total frame statistics.
module frame_buffer
    import orbtrace_pkg::*;
#(
    parameter int BUFFLENLOG2 = 9
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [FRAME_W-1:0]     FrameIn,
    input  logic                   FrameInValid,
    input  logic                   Flush,
    output logic [FRAME_W-1:0]     Frame,
    output logic                   FrameReady,
    input  logic                   FrameNext,
    output logic [BUFFLENLOG2-1:0] FramesCnt,
    output logic [LOST_W-1:0]      LostFrames,
    output logic [TOTAL_W-1:0]     TotalFrames,
    output logic                   Overflow
);

    localparam int B = BUFFLENLOG2;
    localparam logic [B-1:0] ONE  = B'(1);
    localparam logic [B-1:0] FULL = '1;

    logic [B-1:0]       wp;
    logic [B-1:0]       rp;
    hf_state_t          state;
    logic [FRAME_W-1:0] rdata;
    logic               pop;
    logic               full;
    logic               wr;
    logic               drop;
    logic               more;
    logic               rd;

    assign pop  = FrameNext && FrameReady;
    assign full = (FramesCnt == FULL);
    assign wr   = FrameInValid && !Flush && (!full || pop);
    assign drop = FrameInValid && !Flush && full && !pop;
    // wp != rp means RAM holds an entry not yet moved to head
    assign more = (wp != rp);

    always_comb begin
        rd = 1'b0;
        unique case (state)
            HF_EMPTY: rd = more;
            HF_VALID: rd = pop && more;
            default:  rd = 1'b0;
        endcase
    end

    frame_ram #(
        .AW(B)
    ) u_ram (
        .clk   (clk),
        .we    (wr),
        .waddr (wp),
        .wdata (FrameIn),
        .re    (rd),
        .raddr (rp),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            wp          <= '0;
            rp          <= '0;
            state       <= HF_EMPTY;
            Frame       <= '0;
            FrameReady  <= 1'b0;
            FramesCnt   <= '0;
            LostFrames  <= '0;
            TotalFrames <= '0;
            Overflow    <= 1'b0;
        end else begin
            TotalFrames <= TotalFrames + TOTAL_W'(FrameInValid);
            Overflow    <= drop;
            if (drop && (LostFrames != '1)) begin
                LostFrames <= LostFrames + LOST_W'(1);
            end
            if (Flush) begin
                wp         <= '0;
                rp         <= '0;
                FramesCnt  <= '0;
                FrameReady <= 1'b0;
                state      <= HF_EMPTY;
            end else begin
                if (wr) begin
                    wp <= wp + ONE;
                end
                if (rd) begin
                    rp <= rp + ONE;
                end
                FramesCnt <= FramesCnt + B'(wr) - B'(pop);
                unique case (state)
                    HF_EMPTY: begin
                        if (more) begin
                            state <= HF_FETCH;
                        end
                    end
                    HF_FETCH: begin
                        Frame      <= rdata;
                        FrameReady <= 1'b1;
                        state      <= HF_VALID;
                    end
                    HF_VALID: begin
                        if (pop) begin
                            FrameReady <= 1'b0;
                            state <= more ? HF_FETCH : HF_EMPTY;
                        end
                    end
                    default: state <= HF_EMPTY;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frame_buffer.sv
// Randomised and directed checks of frame_buffer against a
// queue-based model of the frame FIFO and its statistics.
module tb_frame_buffer;

    localparam int B   = 3;
    localparam int CAP = 7;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [127:0] FrameIn = '0;
    logic         FrameInValid = 1'b0;
    logic         Flush = 1'b0;
    logic [127:0] Frame;
    logic         FrameReady;
    logic         FrameNext = 1'b0;
    logic [B-1:0] FramesCnt;
    logic [15:0]  LostFrames;
    logic [31:0]  TotalFrames;
    logic         Overflow;

    frame_buffer #(
        .BUFFLENLOG2(B)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .FrameIn      (FrameIn),
        .FrameInValid (FrameInValid),
        .Flush        (Flush),
        .Frame        (Frame),
        .FrameReady   (FrameReady),
        .FrameNext    (FrameNext),
        .FramesCnt    (FramesCnt),
        .LostFrames   (LostFrames),
        .TotalFrames  (TotalFrames),
        .Overflow     (Overflow)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [127:0] a,
                       input logic [127:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    // Reference model: a queue of stored frames plus counters
    logic [127:0] q[$];
    logic [31:0]  m_tot = '0;
    logic [15:0]  m_lost = '0;
    logic         m_ovf = 1'b0;
    logic         popped = 1'b0;
    logic         rdy_s = 1'b0;
    int           bub = 0;
    bit           chk_on = 1'b0;

    always @(posedge clk) begin
        logic p;
        p = FrameNext && rdy_s;
        m_ovf = 1'b0;
        popped = 1'b0;
        if (!rst) begin
            q.delete();
            m_tot = '0;
            m_lost = '0;
        end else begin
            if (FrameInValid) m_tot = m_tot + 1;
            if (Flush) begin
                q.delete();
            end else begin
                if (p) begin
                    void'(q.pop_front());
                    popped = 1'b1;
                end
                if (FrameInValid) begin
                    if (q.size() < CAP) begin
                        q.push_back(FrameIn);
                    end else begin
                        m_ovf = 1'b1;
                        if (m_lost != 16'hFFFF) m_lost = m_lost + 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        rdy_s = FrameReady;
        if (chk_on) begin
            chk("cnt", FramesCnt, q.size());
            chk("total", TotalFrames, m_tot);
            chk("lost", LostFrames, m_lost);
            chk("ovf", Overflow, m_ovf);
            if (FrameReady) begin
                chk("ready_nonempty", q.size() != 0, 1);
                if (q.size() != 0) chk("head", Frame, q[0]);
            end
            if (popped) chk("ready_clr", FrameReady, 0);
            if (q.size() > 0 && !FrameReady) bub++;
            else bub = 0;
            chk("bubble", bub > 2, 0);
        end
    end

    task automatic step(input logic v, input logic [127:0] d,
                        input logic n, input logic f);
        FrameInValid = v;
        FrameIn = d;
        FrameNext = n;
        Flush = f;
        @(posedge clk);
        #1;
        FrameInValid = 1'b0;
        FrameNext = 1'b0;
        Flush = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, '0, 0, 0);
    endtask

    task automatic wait_rdy(input string nm);
        int k = 0;
        while (!FrameReady && k < 8) begin
            idle(1);
            k++;
        end
        chk(nm, FrameReady, 1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle(2);
        rst = 1'b1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [127:0] e[$];
        logic [127:0] v;
        int ovc;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);
        chk_on = 1'b1;
        chk("rst_frame", Frame, 0);
        chk("rst_ready", FrameReady, 0);
        chk("rst_cnt", FramesCnt, 0);
        chk("rst_total", TotalFrames, 0);
        rst = 1'b1;

        // A, B, C back to back, then spaced pops
        step(1, 128'hA, 0, 0);
        chk("cnt1", FramesCnt, 1);
        step(1, 128'hB, 0, 0);
        chk("cnt2", FramesCnt, 2);
        step(1, 128'hC, 0, 0);
        chk("cnt3", FramesCnt, 3);
        chk("a_ready", FrameReady, 1);
        chk("a_frame", Frame, 128'hA);
        for (int i = 0; i < 3; i++) begin
            wait_rdy("abc_wait");
            v = 128'hA + 128'(i);
            chk("abc_head", Frame, v);
            step(0, '0, 1, 0);
            idle(2);
        end
        chk("abc_cnt0", FramesCnt, 0);

        // Overfill a 7-entry FIFO with 9 frames
        do_reset();
        ovc = 0;
        for (int i = 1; i <= 9; i++) begin
            step(1, 128'(i), 0, 0);
            ovc += int'(Overflow);
        end
        chk("fill_cnt", FramesCnt, 7);
        chk("fill_lost", LostFrames, 2);
        chk("fill_total", TotalFrames, 9);
        chk("fill_ovf_pulses", ovc, 2);
        wait_rdy("full_wait");
        chk("full_head", Frame, 1);
        step(1, 128'd100, 1, 0);
        chk("full_wp_cnt", FramesCnt, 7);
        chk("full_wp_lost", LostFrames, 2);
        for (int i = 2; i <= 8; i++) begin
            wait_rdy("drain_wait");
            chk("drain", Frame, (i == 8) ? 128'd100 : 128'(i));
            step(0, '0, 1, 0);
        end
        idle(3);
        chk("drain_cnt0", FramesCnt, 0);

        // Pops while nothing is ready are ignored
        step(0, '0, 1, 0);
        step(0, '0, 1, 0);
        chk("idle_pop_cnt", FramesCnt, 0);
        step(1, 128'hD, 0, 0);
        step(0, '0, 1, 0);
        step(0, '0, 1, 0);
        chk("fetch_pop_cnt", FramesCnt, 1);
        chk("fetch_pop_rdy", FrameReady, 1);
        chk("fetch_pop_head", Frame, 128'hD);
        step(0, '0, 1, 0);

        // Pointer wrap with paired write/pop
        e.delete();
        for (int i = 0; i < 3; i++) begin
            v = rnd128();
            e.push_back(v);
            step(1, v, 0, 0);
        end
        for (int i = 0; i < 20; i++) begin
            wait_rdy("wrap_wait");
            chk("wrap_head", Frame, e[0]);
            void'(e.pop_front());
            v = rnd128();
            e.push_back(v);
            step(1, v, 1, 0);
        end
        while (e.size() > 0) begin
            wait_rdy("wrap_drain_wait");
            chk("wrap_drain", Frame, e[0]);
            void'(e.pop_front());
            step(0, '0, 1, 0);
        end

        // Random traffic, the model checks every cycle
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(999) < 3) begin
                rst = 1'b0;
                idle(1);
                rst = 1'b1;
            end else begin
                step($urandom_range(99) < 50, rnd128(),
                     $urandom_range(99) < 40,
                     $urandom_range(99) < 1);
            end
        end

        // Flush with a simultaneous write, then mid-stream reset
        do_reset();
        for (int i = 0; i < 5; i++) step(1, rnd128(), 0, 0);
        wait_rdy("flush_wait");
        step(1, 128'hEE, 0, 1);
        chk("flush_cnt", FramesCnt, 0);
        chk("flush_rdy", FrameReady, 0);
        chk("flush_total", TotalFrames, 6);
        step(1, 128'h77, 0, 0);
        idle(2);
        chk("post_flush_rdy", FrameReady, 1);
        chk("post_flush_head", Frame, 128'h77);
        step(1, 128'h78, 0, 0);
        rst = 1'b0;
        idle(1);
        rst = 1'b1;
        chk("mid_rst_frame", Frame, 0);
        chk("mid_rst_rdy", FrameReady, 0);
        chk("mid_rst_cnt", FramesCnt, 0);
        chk("mid_rst_lost", LostFrames, 0);
        chk("mid_rst_total", TotalFrames, 0);
        chk("mid_rst_ovf", Overflow, 0);

        // Drive LostFrames to saturation
        for (int i = 0; i < CAP; i++) step(1, rnd128(), 0, 0);
        FrameInValid = 1'b1;
        FrameIn = '0;
        repeat (65534) @(posedge clk);
        #1;
        FrameInValid = 1'b0;
        chk("lost_fffe", LostFrames, 16'hFFFE);
        step(1, '0, 0, 0);
        step(1, '0, 0, 0);
        chk("lost_sat", LostFrames, 16'hFFFF);
        step(1, '0, 0, 0);
        chk("lost_hold", LostFrames, 16'hFFFF);
        chk("sat_cnt", FramesCnt, 7);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
